pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//  Generates a train of rectangular high pulses with programmable high width,
//  low gap and pulse count, all in clock cycles. It is the stimulus/transmit
//  counterpart of pulse_min: it drives test and timing pulses into the MSX-side
//  logic, and is used for loopback calibration of pulse measurement.
//  All settings are latched at start, so they may change while a train runs.
// PARAMETERS
//  N_BITS  8  width of high_len/low_len (pulse and gap length in clocks)
//  C_BITS  8  width of num_pulses (pulses per train)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       request a train; sampled only in IDLE
//  abort       in   1       stop the current train immediately
//  high_len    in   N_BITS  high width in clocks; 0 is treated as 1
//  low_len     in   N_BITS  low gap between pulses in clocks; 0 is treated as 1
//  num_pulses  in   C_BITS  pulses per train; 0 means an empty train
//  pulse_out   out  1       registered pulse output
//  busy        out  1       train in progress (HIGH or LOW state)
//  done        out  1       1-cycle strobe when a train completes normally
// BEHAVIOUR
//  - Reset (async): state=IDLE; pulse_out=0, busy=0, done=0; counters=0.
//  - Outputs come straight from registers and have no combinational path from inputs.
//  - FSM states are IDLE, HIGH and LOW.
//  - IDLE, start=1, abort=0, num_pulses!=0 at edge T:
//    - latch max(high_len,1), max(low_len,1) and num_pulses;
//    - go to HIGH; pulse_out=1 and busy=1 from cycle T+1.
//  - IDLE, start=1, num_pulses=0: stay in IDLE; done=1 for cycle T+1 only; pulse_out stays 0.
//  - HIGH: pulse_out=1 for exactly H latched cycles, then:
//    - more pulses remain -> LOW, pulse_out=0;
//    - last pulse -> IDLE; pulse_out=0, busy=0 and done=1 in that same cycle (no trailing gap).
//  - LOW: pulse_out=0 for exactly L latched cycles, then HIGH.
//  - Pulse period is H+L; a train is N*H+(N-1)*L cycles from the first high to done.
//  - start while busy is ignored (no queueing, no restart).
//  - abort=1 in HIGH or LOW: next cycle pulse_out=0, busy=0, state=IDLE, done stays 0.
//  - abort wins over start in the same cycle; abort in IDLE has no effect.
//  - Length counter: N_BITS down-counter, loaded with len-1 on phase entry;
//    the phase ends when it reads 0. This supports the maximum length 2^N_BITS-1 with no wrap.
//  - Pulse counter: C_BITS down-counter of the remaining pulses, decremented at the end of each HIGH phase.
//  - done is never high for more than 1 cycle; it is 0 whenever busy=1.
//  - Reset mid-train: pulse_out drops asynchronously; no done is issued.
// STRUCTURE
//  - pulse_pkg holds the shared definitions:
//    - typedef enum logic [1:0] {IDLE, HIGH, LOW} pulse_state_t;
//    - the clamp-to-1 function max1(), reused by pulse_min-family blocks.
//  - Sub-module pulse_len_counter (N_BITS): load/value in, decrement, zero flag out.
//    It is instantiated once and reloaded per phase.
//  - Top level holds the FSM, the latched settings, the pulse counter and the output registers.
// TESTING
//  1 high=3, low=2, n=4, start at T
//    -> pulse_out high T+1..T+3, T+6..T+8, T+11..T+13, T+16..T+18;
//    -> done=1 at T+19 only; busy=1 T+1..T+18.
//  2 high=0, low=0, n=2 -> behaves as 1/1: pulses at T+1 and T+3, done at T+4.
//  3 n=0 -> done=1 at T+1, pulse_out never rises, busy stays 0.
//  4 high=5, n=3; abort in the 2nd pulse; start in the same cycle as the abort
//    -> pulse_out=0 and busy=0 next cycle, no done, start not honoured.
//  5 high=255, low=255, n=2 (N_BITS=8)
//    -> each phase lasts exactly 255 cycles; done at T+766.
//    -> change high_len mid-train: widths unaffected.
//  6 Loopback into pulse_min (N_BITS=8), trains of high=9 then high=4
//    -> minimum=4, valid=1.
//    -> Assert reset mid-pulse: pulse_out=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generation / measurement family.
package pulse_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} pulse_state_t;

  localparam int unsigned PULSE_N_BITS = 8;
  localparam int unsigned PULSE_C_BITS = 8;

  // Lengths of 0 are treated as 1 so every phase lasts at least one cycle.
  function automatic logic [31:0] max1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/pulse_len_counter.sv
// Phase length down-counter: load with len-1, phase ends when zero reads 1.
module pulse_len_counter #(
  parameter int unsigned N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [N_BITS-1:0] load_value,
  input  logic              dec,
  output logic              zero
);

  logic [N_BITS-1:0] value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: N pulses of H high cycles separated by L low cycles.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned N_BITS = PULSE_N_BITS,
  parameter int unsigned C_BITS = PULSE_C_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [N_BITS-1:0] high_len,
  input  logic [N_BITS-1:0] low_len,
  input  logic [C_BITS-1:0] num_pulses,
  output logic              pulse_out,
  output logic              busy,
  output logic              done
);

  pulse_state_t      state, state_next;
  logic [N_BITS-1:0] high_lat, high_next;
  logic [N_BITS-1:0] low_lat, low_next;
  logic [C_BITS-1:0] pulse_cnt, pulse_cnt_next;
  logic              pulse_next, busy_next, done_next;
  logic              len_load, len_dec, len_zero;
  logic [N_BITS-1:0] len_load_value;
  logic [31:0]       high_clamp, low_clamp;

  assign high_clamp = max1(32'(high_len));
  assign low_clamp  = max1(32'(low_len));

  pulse_len_counter #(.N_BITS(N_BITS)) u_len (
    .clk        (clk),
    .reset      (reset),
    .load       (len_load),
    .load_value (len_load_value),
    .dec        (len_dec),
    .zero       (len_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      high_lat  <= '0;
      low_lat   <= '0;
      pulse_cnt <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      high_lat  <= high_next;
      low_lat   <= low_next;
      pulse_cnt <= pulse_cnt_next;
      pulse_out <= pulse_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Output registers are fed from next-state values so they align with state.
  always_comb begin
    state_next     = state;
    high_next      = high_lat;
    low_next       = low_lat;
    pulse_cnt_next = pulse_cnt;
    pulse_next     = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    len_load       = 1'b0;
    len_load_value = '0;
    len_dec        = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (num_pulses == '0) begin
            done_next = 1'b1;
          end else begin
            high_next      = high_clamp[N_BITS-1:0];
            low_next       = low_clamp[N_BITS-1:0];
            pulse_cnt_next = num_pulses;
            len_load       = 1'b1;
            len_load_value = high_clamp[N_BITS-1:0] - 1'b1;
            state_next     = HIGH;
            pulse_next     = 1'b1;
            busy_next      = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (len_zero) begin
          pulse_cnt_next = pulse_cnt - 1'b1;
          if (pulse_cnt == C_BITS'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            len_load       = 1'b1;
            len_load_value = low_lat - 1'b1;
            state_next     = LOW;
            busy_next      = 1'b1;
          end
        end else begin
          len_dec    = 1'b1;
          pulse_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_next = IDLE;
        end else if (len_zero) begin
          len_load       = 1'b1;
          len_load_value = high_lat - 1'b1;
          state_next     = HIGH;
          pulse_next     = 1'b1;
          busy_next      = 1'b1;
        end else begin
          len_dec   = 1'b1;
          busy_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen; expected waveforms derived from H, L, N.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] num_pulses = '0;
  logic       pulse_out, busy, done;

  int n_vec = 0;
  int n_miss = 0;

  pulse_train_gen #(.N_BITS(8), .C_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a train at edge T and check every cycle T+1 .. T+total+3.
  // hold_start keeps start asserted while busy; mid_change rewrites settings mid-train.
  task automatic run_train(input int h, input int l, input int n,
                           input bit hold_start, input bit mid_change);
    int he, le, total, pos;
    bit ep, eb, ed;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    total = (n == 0) ? 0 : n * he + (n - 1) * le;
    high_len   = 8'(h);
    low_len    = 8'(l);
    num_pulses = 8'(n);
    start = 1'b1;
    for (int k = 1; k <= total + 3; k++) begin
      step();
      if (!hold_start || k >= total) start = 1'b0;
      if (mid_change && k == 100) begin
        high_len = 8'd3;
        low_len = 8'd7;
        num_pulses = 8'd9;
      end
      if (k <= total) begin
        pos = (k - 1) % (he + le);
        ep = (pos < he);
        eb = 1'b1;
        ed = 1'b0;
      end else begin
        ep = 1'b0;
        eb = 1'b0;
        ed = (k == total + 1);
      end
      chk($sformatf("pulse_h%0d_l%0d_n%0d_k%0d", h, l, n, k), 32'(pulse_out), 32'(ep));
      chk($sformatf("busy_h%0d_l%0d_n%0d_k%0d", h, l, n, k), 32'(busy), 32'(eb));
      chk($sformatf("done_h%0d_l%0d_n%0d_k%0d", h, l, n, k), 32'(done), 32'(ed));
    end
  endtask

  initial begin
    #2;
    chk("reset_pulse", 32'(pulse_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    step();
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Basic train, start held high to confirm no restart while busy.
    run_train(3, 2, 4, 1'b1, 1'b0);
    // Zero lengths clamp to 1.
    run_train(0, 0, 2, 1'b0, 1'b0);
    // Empty train.
    run_train(4, 4, 0, 1'b0, 1'b0);
    // Maximum lengths with settings changed mid-train.
    run_train(255, 255, 2, 1'b0, 1'b1);
    // Single pulse, no trailing gap.
    run_train(1, 9, 1, 1'b0, 1'b0);

    // Abort in second pulse with simultaneous start.
    high_len = 8'd5;
    low_len = 8'd2;
    num_pulses = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 9; k++) step();
    chk("abort_pre_pulse", 32'(pulse_out), 1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_pulse", 32'(pulse_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abort_stays_idle", 32'(busy | pulse_out | done), 0);
    end

    // Abort in IDLE has no effect on a following start.
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_train(2, 1, 2, 1'b0, 1'b0);

    // Reset mid-pulse drops outputs asynchronously.
    high_len = 8'd9;
    num_pulses = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_pulse", 32'(pulse_out), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pulse", 32'(pulse_out), 0);
    chk("async_reset_busy", 32'(busy), 0);
    chk("async_reset_done", 32'(done), 0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_idle", 32'(busy | pulse_out | done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
